// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package regfile_arb_pkg;

    localparam int RADDR_W = 2;
    localparam int WADDR_W = 3;
    localparam logic [WADDR_W-1:0] W_NOP = 3'd4;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_t;

    // Data-width-independent part of a request; wd is appended by the top.
    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] ra1;
        logic [RADDR_W-1:0] ra2;
        logic [RADDR_W-1:0] wa;
    } req_ctl_t;

    function automatic logic [WADDR_W-1:0] w_port(
        input logic [RADDR_W-1:0] wa
    );
        return {1'b0, wa};
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Two-way round-robin arbiter; the last-grant pointer resets to B so A wins
// the first tie.
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig_i,
    output logic [1:0] grant_o
);

    req_id_t last_q;
    req_id_t last_d;

    always_comb begin
        grant_o = 2'b00;
        last_d  = last_q;
        case (elig_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == REQ_B) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (grant_o[0]) begin
            last_d = REQ_A;
        end else if (grant_o[1]) begin
            last_d = REQ_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates register-file access between requesters A and B, one grant per
// cycle, with a one-deep read-response slot per requester.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               a_valid,
    output logic               a_ready,
    input  logic               a_we,
    input  logic [RADDR_W-1:0] a_ra1,
    input  logic [RADDR_W-1:0] a_ra2,
    input  logic [RADDR_W-1:0] a_wa,
    input  logic [N-1:0]       a_wd,
    output logic               a_rvalid,
    input  logic               a_rready,
    output logic [N-1:0]       a_rd1,
    output logic [N-1:0]       a_rd2,

    input  logic               b_valid,
    output logic               b_ready,
    input  logic               b_we,
    input  logic [RADDR_W-1:0] b_ra1,
    input  logic [RADDR_W-1:0] b_ra2,
    input  logic [RADDR_W-1:0] b_wa,
    input  logic [N-1:0]       b_wd,
    output logic               b_rvalid,
    input  logic               b_rready,
    output logic [N-1:0]       b_rd1,
    output logic [N-1:0]       b_rd2,

    output logic [RADDR_W-1:0] rf_r1,
    output logic [RADDR_W-1:0] rf_r2,
    output logic [WADDR_W-1:0] rf_w1,
    output logic [N-1:0]       rf_w,
    input  logic [N-1:0]       rf_v1,
    input  logic [N-1:0]       rf_v2
);

    typedef struct packed {
        req_ctl_t     ctl;
        logic [N-1:0] wd;
    } req_t;

    req_t        req [2];
    req_t        sel;
    logic [1:0]  valid;
    logic [1:0]  rready;
    logic [1:0]  elig;
    logic [1:0]  grant;

    slot_state_t  st_q  [2];
    slot_state_t  st_d  [2];
    logic [N-1:0] rd1_q [2];
    logic [N-1:0] rd1_d [2];
    logic [N-1:0] rd2_q [2];
    logic [N-1:0] rd2_d [2];

    assign req[REQ_A] = {a_we, a_ra1, a_ra2, a_wa, a_wd};
    assign req[REQ_B] = {b_we, b_ra1, b_ra2, b_wa, b_wd};
    assign valid      = {b_valid, a_valid};
    assign rready     = {b_rready, a_rready};

    // Gating with rst_n keeps every request port idle while reset is held.
    always_comb begin
        elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            elig[i] = rst_n & valid[i]
                    & (req[i].ctl.we
                       | (st_q[i] == SLOT_EMPTY)
                       | rready[i]);
        end
    end

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .elig_i  (elig),
        .grant_o (grant)
    );

    assign a_ready = grant[REQ_A];
    assign b_ready = grant[REQ_B];

    always_comb begin
        sel   = grant[REQ_B] ? req[REQ_B] : req[REQ_A];
        rf_r1 = '0;
        rf_r2 = '0;
        rf_w1 = W_NOP;
        rf_w  = '0;
        if (|grant) begin
            if (sel.ctl.we) begin
                rf_w1 = w_port(sel.ctl.wa);
                rf_w  = sel.wd;
            end else begin
                rf_r1 = sel.ctl.ra1;
                rf_r2 = sel.ctl.ra2;
            end
        end
    end

    // A new grant wins over a same-cycle consume so the slot stays FULL.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            rd1_d[i] = rd1_q[i];
            rd2_d[i] = rd2_q[i];
            if (grant[i] && !req[i].ctl.we) begin
                st_d[i]  = SLOT_FULL;
                rd1_d[i] = rf_v1;
                rd2_d[i] = rf_v2;
            end else if (st_q[i] == SLOT_FULL && rready[i]) begin
                st_d[i] = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= SLOT_EMPTY;
                rd1_q[i] <= '0;
                rd2_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                rd1_q[i] <= rd1_d[i];
                rd2_q[i] <= rd2_d[i];
            end
        end
    end

    assign a_rvalid = (st_q[REQ_A] == SLOT_FULL);
    assign b_rvalid = (st_q[REQ_B] == SLOT_FULL);
    assign a_rd1    = rd1_q[REQ_A];
    assign a_rd2    = rd2_q[REQ_A];
    assign b_rd1    = rd1_q[REQ_B];
    assign b_rd2    = rd2_q[REQ_B];

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 4-entry register file.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_clr = 1'b1;

    logic        a_valid, a_ready, a_we, a_rvalid, a_rready;
    logic [1:0]  a_ra1, a_ra2, a_wa;
    logic [31:0] a_wd, a_rd1, a_rd2;
    logic        b_valid, b_ready, b_we, b_rvalid, b_rready;
    logic [1:0]  b_ra1, b_ra2, b_wa;
    logic [31:0] b_wd, b_rd1, b_rd2;
    logic [1:0]  rf_r1, rf_r2;
    logic [2:0]  rf_w1;
    logic [31:0] rf_w, rf_v1, rf_v2;

    logic [31:0] rf [4];

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (rf_w1 != 3'd4) begin
            rf[rf_w1[1:0]] <= rf_w;
        end
    end

    assign rf_v1 = rf[rf_r1];
    assign rf_v2 = rf[rf_r2];

    regfile_arbiter #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
        .a_ra1(a_ra1), .a_ra2(a_ra2), .a_wa(a_wa), .a_wd(a_wd),
        .a_rvalid(a_rvalid), .a_rready(a_rready),
        .a_rd1(a_rd1), .a_rd2(a_rd2),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
        .b_ra1(b_ra1), .b_ra2(b_ra2), .b_wa(b_wa), .b_wd(b_wd),
        .b_rvalid(b_rvalid), .b_rready(b_rready),
        .b_rd1(b_rd1), .b_rd2(b_rd2),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_w1(rf_w1), .rf_w(rf_w),
        .rf_v1(rf_v1), .rf_v2(rf_v2)
    );

    task automatic drive_idle();
        a_valid = 0; a_we = 0; a_ra1 = 0; a_ra2 = 0; a_wa = 0;
        a_wd = 0; a_rready = 0;
        b_valid = 0; b_we = 0; b_ra1 = 0; b_ra2 = 0; b_wa = 0;
        b_wd = 0; b_rready = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        a_valid = 1; a_we = 1; a_wa = 1; a_wd = 32'h11;
        b_valid = 1; b_we = 0; b_ra1 = 2; b_ra2 = 3;
        @(negedge clk); #1;
        vec++; if (a_ready !== 1'b0) begin errs++; $display("FAIL rst_a_ready: got %b want 0", a_ready); end
        vec++; if (b_ready !== 1'b0) begin errs++; $display("FAIL rst_b_ready: got %b want 0", b_ready); end
        vec++; if (rf_w1 !== 3'd4) begin errs++; $display("FAIL rst_rf_w1: got %0d want 4", rf_w1); end
        vec++; if (rf_w !== 32'h0) begin errs++; $display("FAIL rst_rf_w: got %h want 0", rf_w); end
        vec++; if (rf_r1 !== 2'd0 || rf_r2 !== 2'd0) begin errs++; $display("FAIL rst_rf_r: got %0d/%0d want 0/0", rf_r1, rf_r2); end
        vec++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid: got %b/%b want 0/0", a_rvalid, b_rvalid); end
        vec++; if (a_rd1 !== 32'h0 || b_rd1 !== 32'h0) begin errs++; $display("FAIL rst_rd1: got %h/%h want 0/0", a_rd1, b_rd1); end
        drive_idle();
        @(negedge clk);
        rf_clr = 0;
        rst_n = 1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_valid = 1; a_we = 1; a_wa = 1; a_wd = 32'h3;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL wr_ready: got %b want 1", a_ready); end
        vec++; if (rf_w1 !== 3'd1 || rf_w !== 32'h3) begin errs++; $display("FAIL wr_port: got %0d/%h want 1/3", rf_w1, rf_w); end
        @(negedge clk);
        a_we = 0; a_ra1 = 1; a_ra2 = 0;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL rd_ready: got %b want 1", a_ready); end
        vec++; if (rf_r1 !== 2'd1 || rf_w1 !== 3'd4) begin errs++; $display("FAIL rd_port: got r1=%0d w1=%0d want 1/4", rf_r1, rf_w1); end
        @(negedge clk);
        drive_idle(); a_rready = 1;
        #1;
        vec++; if (a_rvalid !== 1'b1) begin errs++; $display("FAIL rd_rvalid: got %b want 1", a_rvalid); end
        vec++; if (a_rd1 !== 32'h3 || a_rd2 !== 32'h0) begin errs++; $display("FAIL rd_data: got %h/%h want 3/0", a_rd1, a_rd2); end
        @(negedge clk);
        a_rready = 0;
        #1;
        vec++; if (a_rvalid !== 1'b0) begin errs++; $display("FAIL rd_drain: got %b want 0", a_rvalid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_valid = 1; a_we = 1; a_wa = 3; a_wd = 32'hffffffff;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL bp_wr: got %b want 1", a_ready); end
        @(negedge clk);
        a_we = 0; a_ra1 = 3; a_ra2 = 1; a_rready = 0;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL bp_rd1_ready: got %b want 1", a_ready); end
        @(negedge clk);
        a_ra1 = 1; a_ra2 = 3;
        #1;
        vec++; if (a_rvalid !== 1'b1 || a_rd1 !== 32'hffffffff || a_rd2 !== 32'h3) begin errs++; $display("FAIL bp_first: got v=%b %h/%h want 1 ffffffff/3", a_rvalid, a_rd1, a_rd2); end
        vec++; if (a_ready !== 1'b0) begin errs++; $display("FAIL bp_stall0: got %b want 0", a_ready); end
        @(negedge clk); #1;
        vec++; if (a_ready !== 1'b0 || a_rd1 !== 32'hffffffff || a_rvalid !== 1'b1) begin errs++; $display("FAIL bp_hold: got rdy=%b v=%b %h want 0 1 ffffffff", a_ready, a_rvalid, a_rd1); end
        @(negedge clk);
        a_rready = 1;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL bp_regrant: got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 0;
        #1;
        vec++; if (a_rvalid !== 1'b1 || a_rd1 !== 32'h3 || a_rd2 !== 32'hffffffff) begin errs++; $display("FAIL bp_second: got v=%b %h/%h want 1 3/ffffffff", a_rvalid, a_rd1, a_rd2); end
        @(negedge clk);
        a_rready = 0;
        #1;
        vec++; if (a_rvalid !== 1'b0) begin errs++; $display("FAIL bp_drain: got %b want 0", a_rvalid); end
    endtask

    task automatic test_idle();
        drive_idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            vec++; if (rf_w1 !== 3'd4) begin errs++; $display("FAIL idle_w1[%0d]: got %0d want 4", k, rf_w1); end
        end
        @(negedge clk);
        a_valid = 1; a_we = 0; a_ra1 = 0; a_ra2 = 1; a_rready = 1;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL idle_rd01: got %b want 1", a_ready); end
        @(negedge clk);
        a_ra1 = 2; a_ra2 = 3;
        #1;
        vec++; if (a_rd1 !== 32'h0 || a_rd2 !== 32'h3) begin errs++; $display("FAIL idle_regs01: got %h/%h want 0/3", a_rd1, a_rd2); end
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL idle_rd23: got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 0;
        #1;
        vec++; if (a_rd1 !== 32'h0 || a_rd2 !== 32'hffffffff) begin errs++; $display("FAIL idle_regs23: got %h/%h want 0/ffffffff", a_rd1, a_rd2); end
        @(negedge clk);
        a_rready = 0;
    endtask

    task automatic test_raw_fair();
        bit granted = 0;
        @(negedge clk);
        b_valid = 1; b_we = 1; b_wa = 3; b_wd = 32'h0;
        #1;
        vec++; if (b_ready !== 1'b1 || rf_w1 !== 3'd3) begin errs++; $display("FAIL raw_bwr: got rdy=%b w1=%0d want 1/3", b_ready, rf_w1); end
        @(negedge clk);
        a_valid = 1; a_we = 0; a_ra1 = 3; a_ra2 = 1;
        for (int k = 0; k < 2 && !granted; k++) begin
            #1;
            if (a_ready === 1'b1) granted = 1;
            else @(negedge clk);
        end
        vec++; if (!granted) begin errs++; $display("FAIL fair_a: got not granted in 2 cycles want granted"); end
        vec++; if (b_ready !== 1'b0) begin errs++; $display("FAIL fair_b_excl: got %b want 0", b_ready); end
        @(negedge clk);
        drive_idle(); a_rready = 1;
        #1;
        vec++; if (a_rvalid !== 1'b1 || a_rd1 !== 32'h0 || a_rd2 !== 32'h3) begin errs++; $display("FAIL raw_data: got v=%b %h/%h want 1 0/3", a_rvalid, a_rd1, a_rd2); end
        @(negedge clk);
        a_rready = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b_valid = 1; b_we = 0; b_ra1 = 1; b_ra2 = 3; b_rready = 0;
        #1;
        vec++; if (b_ready !== 1'b1) begin errs++; $display("FAIL rm_bread: got %b want 1", b_ready); end
        @(negedge clk);
        b_valid = 0;
        a_valid = 1; a_we = 1; a_wa = 2; a_wd = 32'h55;
        #1;
        vec++; if (b_rvalid !== 1'b1 || b_rd1 !== 32'h3) begin errs++; $display("FAIL rm_bfull: got v=%b %h want 1 3", b_rvalid, b_rd1); end
        vec++; if (a_ready !== 1'b1 || rf_w1 !== 3'd2) begin errs++; $display("FAIL rm_awr: got rdy=%b w1=%0d want 1/2", a_ready, rf_w1); end
        #1 rst_n = 0;
        #1;
        vec++; if (b_rvalid !== 1'b0 || b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin errs++; $display("FAIL rm_bclear: got v=%b %h/%h want 0 0/0", b_rvalid, b_rd1, b_rd2); end
        vec++; if (a_ready !== 1'b0 || rf_w1 !== 3'd4) begin errs++; $display("FAIL rm_gate: got rdy=%b w1=%0d want 0/4", a_ready, rf_w1); end
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        #1;
        vec++; if (rf[2] !== 32'h0) begin errs++; $display("FAIL rm_lost_wr: got reg2=%h want 0", rf[2]); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_w1;
        @(negedge clk);
        a_valid = 1; a_we = 1; a_wa = 0; a_wd = 32'h1;
        b_valid = 1; b_we = 1; b_wa = 2; b_wd = 32'h7;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_w1 = (k % 2 == 0) ? 3'd0 : 3'd2;
            vec++; if (rf_w1 !== exp_w1) begin errs++; $display("FAIL cont_w1[%0d]: got %0d want %0d", k, rf_w1, exp_w1); end
            vec++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin errs++; $display("FAIL cont_rdy[%0d]: got %b%b", k, a_ready, b_ready); end
        end
        @(negedge clk);
        drive_idle();
        a_valid = 1; a_we = 0; a_ra1 = 0; a_ra2 = 2; a_rready = 1;
        #1;
        vec++; if (a_ready !== 1'b1) begin errs++; $display("FAIL cont_rd: got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 0;
        #1;
        vec++; if (a_rd1 !== 32'h1 || a_rd2 !== 32'h7) begin errs++; $display("FAIL cont_regs: got %h/%h want 1/7", a_rd1, a_rd2); end
        @(negedge clk);
        a_rready = 0;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write_read();
        test_backpressure();
        test_idle();
        test_raw_fair();
        test_reset_mid();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
